// File: rtl/inputc_ctrl_pkg.sv
// Shared definitions for the router input-channel controller: flit encodings,
// output-port ids, header field offsets, FSM states and the XY routing function.
package inputc_ctrl_pkg;

  localparam int unsigned PortIdW = 2;  // port id is PortIdW+1 bits wide
  localparam int unsigned PortMax = 4;  // grant vector is PortMax+1 bits wide
  localparam int unsigned CoordW  = 4;
  localparam int unsigned DstXLsb = 4;
  localparam int unsigned DstYLsb = 0;

  typedef logic [PortIdW:0] port_t;

  localparam port_t PortN = 3'd0;
  localparam port_t PortE = 3'd1;
  localparam port_t PortS = 3'd2;
  localparam port_t PortW = 3'd3;
  localparam port_t PortL = 3'd4;

  typedef enum logic [1:0] {
    FlitBody   = 2'b00,
    FlitHead   = 2'b01,
    FlitTail   = 2'b10,
    FlitSingle = 2'b11
  } flit_type_e;

  typedef enum logic [1:0] {StIdle, StRoute, StReq, StXfer} state_e;

  // Dimension-ordered routing: resolve X first, then Y, then eject locally.
  function automatic port_t xy_route(input logic [CoordW-1:0] myx, input logic [CoordW-1:0] myy,
                                     input logic [CoordW-1:0] dx, input logic [CoordW-1:0] dy);
    if (dx > myx)      return PortE;
    else if (dx < myx) return PortW;
    else if (dy > myy) return PortS;
    else if (dy < myy) return PortN;
    else               return PortL;
  endfunction

endpackage

// File: rtl/inputc_ctrl_if.sv
// Flit and arbitration signals between an input channel, its upstream link,
// the five output arbiters and the crossbar.
interface inputc_ctrl_if #(
  parameter int unsigned DATAW = 32
);
  import inputc_ctrl_pkg::*;

  logic [DATAW-1:0] in_flit;
  logic             in_valid;
  logic             in_ready;
  port_t            port;
  logic             req;
  logic             fwdab;
  logic [PortMax:0] grt_in;
  logic [DATAW-1:0] out_flit;
  logic             out_valid;
  logic             out_ready;

  modport master (
    input  in_flit, in_valid, grt_in, out_ready,
    output in_ready, port, req, fwdab, out_flit, out_valid
  );

  modport slave (
    output in_flit, in_valid, grt_in, out_ready,
    input  in_ready, port, req, fwdab, out_flit, out_valid
  );

endinterface

// File: rtl/inputc_ctrl_flit_fifo.sv
// Flit buffer: DEPTH x DATAW circular FIFO with first-word fall-through read.
module inputc_ctrl_flit_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DATAW = 32
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             push,
  input  logic [DATAW-1:0] wdata,
  input  logic             pop,
  output logic [DATAW-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CntW = AW + 1;

  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [DATAW-1:0] mem_q [DEPTH];
  logic             push_ok, pop_ok;

  assign full    = (cnt_q == CntW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem_q[rptr_q];

  always_comb begin
    cnt_d = cnt_q;
    if (push_ok && !pop_ok)      cnt_d = cnt_q + 1'b1;
    else if (!push_ok && pop_ok) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop_ok)  rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/inputc_ctrl.sv
// Router input-channel controller: buffers flits, XY-routes each head, requests
// the chosen output arbiter and streams the packet through while granted.
module inputc_ctrl
  import inputc_ctrl_pkg::*;
#(
  parameter logic [3:0]  MYX   = 4'd0,
  parameter logic [3:0]  MYY   = 4'd0,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DATAW = 32
) (
  input logic          clk,
  input logic          rst_,
  inputc_ctrl_if.master bus
);

  logic [DATAW-1:0] head;
  logic             full, empty, push, pop;
  logic             grant, head_start, head_end, out_valid, xfer_pop;
  logic [7:0]       grt_ext;
  state_e           state_q;
  port_t            port_q;
  logic             req_q, fwdab_q;

  // Type 01/11 opens a packet, type 10/11 closes it.
  assign head_start = head[DATAW-2];
  assign head_end   = head[DATAW-1];

  assign grt_ext   = {{(7 - PortMax){1'b0}}, bus.grt_in};
  assign grant     = grt_ext[port_q];
  assign out_valid = (state_q == StXfer) && grant && !empty;
  assign xfer_pop  = out_valid && bus.out_ready;
  // Non-head flits at the front while idle are protocol errors and are discarded.
  assign pop  = xfer_pop || ((state_q == StIdle) && !empty && !head_start);
  assign push = bus.in_valid && !full;

  assign bus.in_ready  = !full;
  assign bus.out_flit  = head;
  assign bus.out_valid = out_valid;
  assign bus.port      = port_q;
  assign bus.req       = req_q;
  assign bus.fwdab     = fwdab_q;

  inputc_ctrl_flit_fifo #(
    .DEPTH (DEPTH),
    .DATAW (DATAW)
  ) u_fifo (
    .clk   (clk),
    .rst_  (rst_),
    .push  (push),
    .wdata (bus.in_flit),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= StIdle;
      port_q  <= PortN;
      req_q   <= 1'b0;
      fwdab_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (!empty && head_start) state_q <= StRoute;
        end
        StRoute: begin
          port_q  <= xy_route(MYX, MYY, head[DstXLsb +: CoordW], head[DstYLsb +: CoordW]);
          fwdab_q <= head[DATAW-3];
          req_q   <= 1'b1;
          state_q <= StReq;
        end
        StReq: begin
          if (grant) state_q <= StXfer;
        end
        StXfer: begin
          // Request is held through the tail so the arbiter keeps the grant.
          if (xfer_pop && head_end) begin
            req_q   <= 1'b0;
            fwdab_q <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
